// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store alignment unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // Access size as log2(bytes); the unsigned load encodings share the low bits.
    function automatic logic [1:0] size_log2(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

    function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3,
                                        input int xlen);
        logic wide_op;
        wide_op = (funct3 == F3_D) || (!is_store && funct3 == F3_WU);
        if (is_store)
            return funct3[2] || (xlen == 32 && wide_op);
        return (funct3 == 3'd7) || (xlen == 32 && wide_op);
    endfunction

endpackage

// File: rtl/lsu_lane_extend.sv
// Picks the addressed lane out of a memory word and sign/zero-extends it; the
// unshifted lane mask is exported so the store merge can reuse it.
module lsu_lane_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]           word,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [2:0]                funct3,
    output logic [XLEN-1:0]           result,
    output logic [XLEN-1:0]           mask
);

    logic [XLEN-1:0] lane;
    logic            msb;

    always_comb begin
        lane = word >> {offset, 3'b000};
        case (size_log2(funct3))
            2'd0: begin mask = XLEN'(8'hFF);          msb = lane[7];      end
            2'd1: begin mask = XLEN'(16'hFFFF);       msb = lane[15];     end
            2'd2: begin mask = XLEN'(32'hFFFF_FFFF);  msb = lane[31];     end
            default: begin mask = '1;                 msb = lane[XLEN-1]; end
        endcase
        result = (lane & mask) | ({XLEN{msb & ~funct3[2]}} & ~mask);
    end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: single outstanding request, read-modify-write for
// sub-word stores, misaligned/illegal requests answered without touching memory.
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misaligned,
    output logic            resp_illegal,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam int CW   = $clog2(MEM_LATENCY + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [OFFW-1:0] off_q;
    logic [XLEN-1:0] wdata_q;

    logic [1:0]      req_size;
    logic            req_ill, req_mis, req_full;

    always_comb begin
        req_size = size_log2(req_funct3);
        req_ill  = is_illegal(req_is_store, req_funct3, XLEN);
        case (req_size)
            2'd0:    req_mis = 1'b0;
            2'd1:    req_mis = req_addr[0];
            2'd2:    req_mis = |req_addr[1:0];
            default: req_mis = |req_addr[2:0];
        endcase
        req_full = (int'(req_size) == OFFW);
    end

    logic [XLEN-1:0] lane_result, lane_mask, byte_sel, merged;

    lsu_lane_extend #(.XLEN(XLEN)) u_lane (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .result (lane_result),
        .mask   (lane_mask)
    );

    // Store bytes land at the lane position; everything else keeps the read word.
    assign byte_sel = lane_mask << {off_q, 3'b000};
    assign merged   = (mem_rdata & ~byte_sel) | ((wdata_q << {off_q, 3'b000}) & byte_sel);

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            is_store_q      <= 1'b0;
            funct3_q        <= '0;
            off_q           <= '0;
            wdata_q         <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
            mem_addr        <= '0;
            mem_wr          <= 1'b0;
            mem_wdata       <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_wr     <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    is_store_q <= req_is_store;
                    funct3_q   <= req_funct3;
                    off_q      <= req_addr[OFFW-1:0];
                    wdata_q    <= req_wdata;
                    mem_addr   <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    if (req_ill || req_mis) begin
                        state           <= RESP;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= '0;
                        resp_misaligned <= req_mis & ~req_ill;
                        resp_illegal    <= req_ill;
                    end else if (req_is_store && req_full) begin
                        // Whole-word store has nothing to preserve, so no read.
                        state     <= WRITE;
                        mem_wr    <= 1'b1;
                        mem_wdata <= req_wdata;
                    end else begin
                        state <= READ;
                        cnt   <= CW'(MEM_LATENCY - 1);
                    end
                end
                READ: begin
                    if (cnt == '0) begin
                        if (is_store_q) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= merged;
                        end else begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= lane_result;
                            resp_misaligned <= 1'b0;
                            resp_illegal    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WRITE: begin
                    state           <= RESP;
                    resp_valid      <= 1'b1;
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                    resp_illegal    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench: 64-bit unit with 3-cycle memory, plus a 32-bit unit for XLEN=32 rules.
module tb_lsu_align_unit;
    import lsu_pkg::*;

    localparam int L = 3;
    localparam logic [63:0] W0 = 64'h0000_0000_8000_00F0;
    localparam logic [63:0] W1 = 64'h7FFF_FFFF_0000_0000;
    localparam logic [63:0] W2 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W3 = 64'h8000_0001_0000_0000;
    localparam logic [63:0] W4 = 64'h0123_4567_89AB_CDEF;

    logic clk = 0, reset = 1, preload = 1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_ready, req_is_store = 0, resp_valid, resp_misaligned, resp_illegal;
    logic [2:0]  req_funct3 = 0;
    logic [63:0] req_addr = 0, req_wdata = 0, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;

    lsu_align_unit #(.XLEN(64), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic        rv32 = 0, rr32, st32 = 0, vv32, mis32, ill32, mw32;
    logic [2:0]  f332 = 0;
    logic [31:0] a32 = 0, wd32 = 0, rd32, ma32, mwd32;
    logic [31:0] mrd32 = 32'hCAFE_F00D;

    lsu_align_unit #(.XLEN(32), .MEM_LATENCY(1)) dut32 (
        .clk(clk), .reset(reset), .req_valid(rv32), .req_ready(rr32),
        .req_is_store(st32), .req_funct3(f332), .req_addr(a32),
        .req_wdata(wd32), .resp_valid(vv32), .resp_rdata(rd32),
        .resp_misaligned(mis32), .resp_illegal(ill32),
        .mem_addr(ma32), .mem_wr(mw32), .mem_wdata(mwd32), .mem_rdata(mrd32)
    );

    // Memory model: address sampled, data returned MEM_LATENCY edges after launch.
    logic [63:0] mem [16];
    logic [63:0] dly [2];
    always @(posedge clk) begin
        dly[0] <= mem_addr;
        dly[1] <= dly[0];
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
            mem[0] <= W0; mem[1] <= W1; mem[2] <= W2; mem[3] <= W3; mem[4] <= W4;
        end else if (mem_wr) begin
            mem[mem_addr[6:3]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[dly[1][6:3]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] rd; logic mis; logic ill; int cyc; } resp_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; int cyc; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];
    resp_t re;
    wr_t   we;
    int n_checks = 0, n_fail = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                n_checks++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, need no response", cyc);
                end else begin
                    re = rq.pop_front();
                    if (resp_rdata !== re.rd || resp_misaligned !== re.mis || resp_illegal !== re.ill || cyc != re.cyc) begin
                        n_fail++;
                        $display("FAIL resp: got rdata=%h mis=%b ill=%b cyc=%0d, need rdata=%h mis=%b ill=%b cyc=%0d",
                                 resp_rdata, resp_misaligned, resp_illegal, cyc, re.rd, re.mis, re.ill, re.cyc);
                    end
                end
            end
            if (mem_wr) begin
                n_checks++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: mem_wr=1 addr=%h at cycle %0d, need no write", mem_addr, cyc);
                end else begin
                    we = wq.pop_front();
                    if (mem_addr !== we.addr || mem_wdata !== we.data || cyc != we.cyc) begin
                        n_fail++;
                        $display("FAIL write: got addr=%h data=%h cyc=%0d, need addr=%h data=%h cyc=%0d",
                                 mem_addr, mem_wdata, cyc, we.addr, we.data, we.cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] erd, input logic emis, input logic eill, input int rlat,
                        input logic ewr, input logic [63:0] ewd, input int wlat);
        int n = 0;
        resp_t r;
        wr_t w;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: req_ready=%b, need 1", req_ready);
        end
        req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        r.rd = erd; r.mis = emis; r.ill = eill; r.cyc = cyc + rlat;
        rq.push_back(r);
        if (ewr) begin
            w.addr = {a[63:3], 3'b000}; w.data = ewd; w.cyc = cyc + wlat;
            wq.push_back(w);
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] erd);
        send(1'b0, f3, a, 64'h0, erd, 1'b0, 1'b0, L + 1, 1'b0, 64'h0, 0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] ewd, input logic full);
        send(1'b1, f3, a, wd, 64'h0, 1'b0, 1'b0, full ? 2 : L + 2, 1'b1, ewd, full ? 1 : L + 1);
    endtask

    task automatic fault(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic emis, input logic eill);
        send(st, f3, a, 64'h5A5A_5A5A, 64'h0, emis, eill, 1, 1'b0, 64'h0, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rq.size() != 0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses and %0d writes outstanding, need 0", tag, rq.size(), wq.size());
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b resp_valid=%b mem_wr=%b, need 1 0 0", req_ready, resp_valid, mem_wr);
        end
        n_checks++;
        if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || resp_rdata !== 64'h0 || resp_misaligned !== 1'b0 || resp_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h mis=%b ill=%b, need all 0",
                     mem_addr, mem_wdata, resp_rdata, resp_misaligned, resp_illegal);
        end
        preload = 0;
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_load_extend();
        load(F3_B,  64'h00, 64'hFFFF_FFFF_FFFF_FFF0);
        load(F3_BU, 64'h00, 64'h0000_0000_0000_00F0);
        load(F3_H,  64'h02, 64'hFFFF_FFFF_FFFF_8000);
        load(F3_HU, 64'h02, 64'h0000_0000_0000_8000);
        load(F3_W,  64'h0C, 64'h0000_0000_7FFF_FFFF);
        load(F3_W,  64'h1C, 64'hFFFF_FFFF_8000_0001);
        load(F3_WU, 64'h1C, 64'h0000_0000_8000_0001);
        load(F3_D,  64'h08, W1);
        load(F3_B,  64'h1F, 64'hFFFF_FFFF_FFFF_FF80);
        drain("load");
    endtask

    task automatic test_store_merge();
        store(F3_B, 64'h12, 64'hFFFF_FFFF_FFFF_FFAB, 64'h1111_1111_11AB_1111, 1'b0);
        store(F3_H, 64'h16, 64'h0000_0000_0000_BEEF, 64'hBEEF_1111_11AB_1111, 1'b0);
        store(F3_W, 64'h10, 64'hFFFF_FFFF_0123_4567, 64'hBEEF_1111_0123_4567, 1'b0);
        store(F3_D, 64'h28, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        load(F3_D,  64'h10, 64'hBEEF_1111_0123_4567);
        load(F3_BU, 64'h2D, 64'h0000_0000_0000_00BE);
        drain("store");
    endtask

    task automatic test_faults();
        fault(1'b0, F3_W, 64'h102, 1'b1, 1'b0);
        fault(1'b0, F3_H, 64'h001, 1'b1, 1'b0);
        fault(1'b1, F3_D, 64'h00C, 1'b1, 1'b0);
        fault(1'b1, F3_H, 64'h011, 1'b1, 1'b0);
        fault(1'b0, 3'd7, 64'h000, 1'b0, 1'b1);
        fault(1'b1, 3'd5, 64'h000, 1'b0, 1'b1);
        fault(1'b0, 3'd7, 64'h003, 1'b0, 1'b1);
        drain("fault");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            int idx, off;
            logic [63:0] w;
            logic [7:0]  b;
            logic [15:0] h;
            idx = $urandom_range(0, 1);
            w = idx ? W1 : W0;
            off = $urandom_range(0, 7);
            b = 8'(w >> (8 * off));
            load(F3_B, 64'(idx * 8 + off), {{56{b[7]}}, b});
            off = 2 * $urandom_range(0, 3);
            h = 16'(w >> (8 * off));
            load(F3_HU, 64'(idx * 8 + off), {48'h0, h});
        end
        drain("b2b");
    endtask

    task automatic test_reset_midop(input logic st, input logic [63:0] a);
        @(negedge clk);
        req_valid = 1; req_is_store = st; req_funct3 = st ? F3_B : F3_D; req_addr = a; req_wdata = 64'hEE;
        @(negedge clk);
        req_valid = 0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_busy: req_ready=%b, need 0", req_ready);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_release: ready=%b resp_valid=%b mem_wr=%b, need 1 0 0", req_ready, resp_valid, mem_wr);
        end
        drain("midop");
    endtask

    task automatic xl32(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic ei, input int elat,
                        input logic ewr, input logic [31:0] ewd);
        int lat = 0;
        logic got = 0, saw_wr = 0, ill = 0, mis = 0;
        logic [31:0] rd = 0, wrd = 0, wa = 0;
        @(negedge clk);
        rv32 = 1; st32 = st; f332 = f3; a32 = a; wd32 = wd;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rv32 = 0;
            if (mw32) begin saw_wr = 1; wrd = mwd32; wa = ma32; end
            if (vv32 && !got) begin got = 1; lat = k; rd = rd32; ill = ill32; mis = mis32; end
        end
        n_checks++;
        if (!got || lat != elat || rd !== erd || ill !== ei || mis !== 1'b0 || saw_wr !== ewr ||
            (ewr && (wrd !== ewd || wa !== {a[31:2], 2'b00}))) begin
            n_fail++;
            $display("FAIL x32_f%0d_a%h: resp=%b lat=%0d rdata=%h ill=%b mis=%b wr=%b wdata=%h, need lat=%0d rdata=%h ill=%b mis=0 wr=%b wdata=%h",
                     f3, a, got, lat, rd, ill, mis, saw_wr, wrd, elat, erd, ei, ewr, ewd);
        end
    endtask

    task automatic test_xlen32();
        xl32(1'b0, F3_D,  32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        xl32(1'b0, F3_WU, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        xl32(1'b1, F3_D,  32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        xl32(1'b0, F3_B,  32'h1, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1'b0, 32'h0);
        xl32(1'b0, F3_HU, 32'h2, 32'h0, 32'h0000_CAFE, 1'b0, 2, 1'b0, 32'h0);
        xl32(1'b0, F3_H,  32'h2, 32'h0, 32'hFFFF_CAFE, 1'b0, 2, 1'b0, 32'h0);
        xl32(1'b1, F3_W,  32'h4, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b1, 32'h1234_5678);
        xl32(1'b1, F3_B,  32'h1, 32'hFFFF_FF55, 32'h0, 1'b0, 3, 1'b1, 32'hCAFE_550D);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_extend();
        test_store_merge();
        test_faults();
        test_back_to_back();
        test_xlen32();
        test_reset_midop(1'b0, 64'h08);
        test_reset_midop(1'b1, 64'h20);
        load(F3_D, 64'h20, W4);
        drain("post_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
